// File: rtl/imem_prefetch_buffer.sv
// Instruction fetch front end: credit-limited in-order word fetches, a PC tag queue
// matching responses to addresses, and a {pc, instr} FIFO handed to IF with valid/ready.
module imem_prefetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        protocol_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetchEntry_t;

    logic [31:0]   fetchPc;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discardCnt;
    logic [CW-1:0] inUse;
    logic [PW-1:0] fifoRd;
    logic [PW-1:0] fifoWr;
    logic [PW-1:0] tagRd;
    logic [PW-1:0] tagWr;

    fetchEntry_t fifoMem [DEPTH];
    logic [31:0] tagMem  [DEPTH];

    logic accept;
    logic rspOk;
    logic rspErr;
    logic rspDrop;
    logic fifoPush;
    logic fifoPop;

    // Buffered plus in-flight never exceeds DEPTH, so a response always has FIFO room.
    assign inUse    = count + outstanding;
    assign mem_req  = !reset && !redirect_valid && (inUse < CW'(DEPTH));
    assign mem_addr = fetchPc;
    assign accept   = mem_req && mem_gnt;

    assign rspOk    = mem_rvalid && (outstanding != '0);
    assign rspErr   = mem_rvalid && (outstanding == '0);
    assign rspDrop  = redirect_valid || (discardCnt != '0);
    assign fifoPush = rspOk && !rspDrop;
    assign fifoPop  = if_valid && if_ready && !redirect_valid;

    assign if_valid = (count != '0);
    assign if_pc    = if_valid ? fifoMem[fifoRd].pc    : '0;
    assign if_instr = if_valid ? fifoMem[fifoRd].instr : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetchPc      <= RESET_PC;
            count        <= '0;
            outstanding  <= '0;
            discardCnt   <= '0;
            fifoRd       <= '0;
            fifoWr       <= '0;
            tagRd        <= '0;
            tagWr        <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (accept) begin
                fetchPc <= fetchPc + 32'd4;
                tagWr   <= tagWr + PW'(1);
            end
            if (rspOk)
                tagRd <= tagRd + PW'(1);
            outstanding  <= outstanding + CW'(accept) - CW'(rspOk);
            protocol_err <= protocol_err | rspErr;

            if (redirect_valid) begin
                // Everything still in flight after this edge belongs to the old path.
                fetchPc    <= {redirect_pc[31:2], 2'b00};
                discardCnt <= outstanding - CW'(rspOk);
                count      <= '0;
                fifoRd     <= fifoWr;
            end else begin
                if (rspOk && (discardCnt != '0))
                    discardCnt <= discardCnt - CW'(1);
                if (fifoPush)
                    fifoWr <= fifoWr + PW'(1);
                if (fifoPop)
                    fifoRd <= fifoRd + PW'(1);
                count <= count + CW'(fifoPush) - CW'(fifoPop);
            end
        end
    end

    // Storage needs no reset: occupancy counters gate every read.
    always_ff @(posedge clk) begin
        if (accept)
            tagMem[tagWr] <= fetchPc;
        if (fifoPush)
            fifoMem[fifoWr] <= '{pc: tagMem[tagRd], instr: mem_rdata};
    end

endmodule

// File: tb/tb_imem_prefetch_buffer.sv
// Directed bench for imem_prefetch_buffer: a vector table for steady streaming plus
// hand-written multi-cycle sequences for backpressure, redirect, protocol error and reset.
module tb_imem_prefetch_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        protocol_err;

    int passed = 0;
    int total  = 0;

    imem_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        eValid;
        logic [31:0] ePc;
        logic [31:0] eInstr;
        logic        eReq;
        logic [31:0] eAddr;
        logic        eErr;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic chkOut(input string nm, input logic v, input logic [31:0] pc,
                          input logic [31:0] ins, input logic req, input logic [31:0] addr,
                          input logic err);
        chk({nm, ".if_valid"}, 32'(if_valid), 32'(v));
        chk({nm, ".if_pc"}, if_pc, pc);
        chk({nm, ".if_instr"}, if_instr, ins);
        chk({nm, ".mem_req"}, 32'(mem_req), 32'(req));
        chk({nm, ".mem_addr"}, mem_addr, addr);
        chk({nm, ".protocol_err"}, 32'(protocol_err), 32'(err));
    endtask

    // Drive one cycle's inputs away from the rising edge, then let combinational outputs settle.
    task automatic setIn(input logic rd, input logic [31:0] rpc, input logic rdy,
                         input logic g, input logic rv, input logic [31:0] rdt);
        @(negedge clk);
        redirect_valid = rd;
        redirect_pc    = rpc;
        if_ready       = rdy;
        mem_gnt        = g;
        mem_rvalid     = rv;
        mem_rdata      = rdt;
        #1;
    endtask

    task automatic doRst(input string nm);
        @(negedge clk);
        reset = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #1;
        chkOut(nm, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // Streaming: grant always, 1-cycle response, data = addr ^ A5A5_0000, IF always ready.
        vecs[0] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0,
                    1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0};
        vecs[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hA5A5_0000,
                    1'b0, 32'h0, 32'h0, 1'b1, 32'h4, 1'b0};
        vecs[2] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hA5A5_0004,
                    1'b1, 32'h0, 32'hA5A5_0000, 1'b1, 32'h8, 1'b0};
        vecs[3] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hA5A5_0008,
                    1'b1, 32'h4, 32'hA5A5_0004, 1'b1, 32'hC, 1'b0};
        vecs[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hA5A5_000C,
                    1'b1, 32'h8, 32'hA5A5_0008, 1'b1, 32'h10, 1'b0};
        vecs[5] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hA5A5_0010,
                    1'b1, 32'hC, 32'hA5A5_000C, 1'b1, 32'h14, 1'b0};

        #2;
        chkOut("init", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        doRst("rst0");

        for (int i = 0; i < 6; i++) begin
            setIn(vecs[i].redir, vecs[i].rpc, vecs[i].rdy, vecs[i].gnt, vecs[i].rv, vecs[i].rdata);
            chkOut($sformatf("stream.r%0d", i), vecs[i].eValid, vecs[i].ePc, vecs[i].eInstr,
                   vecs[i].eReq, vecs[i].eAddr, vecs[i].eErr);
        end

        // Backpressure: exactly four grants, then stall; release and refill one per pop.
        doRst("rstB");
        setIn(0, 0, 0, 1, 0, 0);                 chk("B.c0.addr", mem_addr, 32'h0);
        setIn(0, 0, 0, 1, 1, 32'hA5A5_0000);     chk("B.c1.addr", mem_addr, 32'h4);
        setIn(0, 0, 0, 1, 1, 32'hA5A5_0004);     chk("B.c2.addr", mem_addr, 32'h8);
        setIn(0, 0, 0, 1, 1, 32'hA5A5_0008);     chk("B.c3.addr", mem_addr, 32'hC);
        chk("B.c3.req", 32'(mem_req), 32'h1);
        setIn(0, 0, 0, 1, 1, 32'hA5A5_000C);     chk("B.c4.req", 32'(mem_req), 32'h0);
        setIn(0, 0, 0, 1, 0, 0);
        chkOut("B.c5", 1'b1, 32'h0, 32'hA5A5_0000, 1'b0, 32'h10, 1'b0);
        setIn(0, 0, 1, 1, 0, 0);
        chkOut("B.c5pop", 1'b1, 32'h0, 32'hA5A5_0000, 1'b0, 32'h10, 1'b0);
        setIn(0, 0, 1, 1, 0, 0);
        chkOut("B.c6", 1'b1, 32'h4, 32'hA5A5_0004, 1'b1, 32'h10, 1'b0);
        setIn(0, 0, 1, 1, 1, 32'hA5A5_0010);
        chkOut("B.c7", 1'b1, 32'h8, 32'hA5A5_0008, 1'b1, 32'h14, 1'b0);
        setIn(0, 0, 1, 0, 1, 32'hA5A5_0014);
        chkOut("B.c8", 1'b1, 32'hC, 32'hA5A5_000C, 1'b1, 32'h18, 1'b0);
        setIn(0, 0, 1, 0, 0, 0);
        chkOut("B.c9", 1'b1, 32'h10, 32'hA5A5_0010, 1'b1, 32'h18, 1'b0);
        setIn(0, 0, 1, 0, 0, 0);
        chkOut("B.c10", 1'b1, 32'h14, 32'hA5A5_0014, 1'b1, 32'h18, 1'b0);
        setIn(0, 0, 1, 0, 0, 0);
        chk("B.c11.empty", 32'(if_valid), 32'h0);

        // Redirect with two 3-cycle responses in flight; both must be discarded.
        doRst("rstC");
        setIn(0, 0, 1, 1, 0, 0);                 chk("C.c0.addr", mem_addr, 32'h0);
        setIn(0, 0, 1, 1, 0, 0);                 chk("C.c1.addr", mem_addr, 32'h4);
        setIn(1, 32'h0000_0103, 1, 1, 0, 0);     chk("C.c2.req", 32'(mem_req), 32'h0);
        setIn(0, 0, 1, 1, 1, 32'hDEAD_0000);
        chkOut("C.c3", 1'b0, 32'h0, 32'h0, 1'b1, 32'h100, 1'b0);
        setIn(0, 0, 1, 0, 1, 32'hDEAD_0004);
        chkOut("C.c4", 1'b0, 32'h0, 32'h0, 1'b1, 32'h104, 1'b0);
        setIn(0, 0, 1, 0, 0, 0);
        chkOut("C.c5", 1'b0, 32'h0, 32'h0, 1'b1, 32'h104, 1'b0);
        setIn(0, 0, 0, 0, 1, 32'h1000_0100);     chk("C.c6.valid", 32'(if_valid), 32'h0);
        setIn(0, 0, 0, 0, 0, 0);
        chkOut("C.c7", 1'b1, 32'h100, 32'h1000_0100, 1'b1, 32'h104, 1'b0);

        // Redirect coinciding with a response and a pop; one more stale response follows.
        doRst("rstD");
        setIn(0, 0, 0, 1, 0, 0);
        setIn(0, 0, 0, 1, 0, 0);
        setIn(0, 0, 0, 1, 1, 32'h3000_0000);
        setIn(1, 32'h0000_0200, 1, 1, 1, 32'hBAD0_0004);
        chkOut("D.c3", 1'b1, 32'h0, 32'h3000_0000, 1'b0, 32'hC, 1'b0);
        setIn(0, 0, 1, 1, 1, 32'hBAD0_0008);
        chkOut("D.c4", 1'b0, 32'h0, 32'h0, 1'b1, 32'h200, 1'b0);
        setIn(0, 0, 1, 0, 1, 32'h2000_0200);
        chkOut("D.c5", 1'b0, 32'h0, 32'h0, 1'b1, 32'h204, 1'b0);
        setIn(0, 0, 0, 0, 0, 0);
        chkOut("D.c6", 1'b1, 32'h200, 32'h2000_0200, 1'b1, 32'h204, 1'b0);

        // Spurious responses: sticky error, no counter underflow, FIFO untouched.
        doRst("rstE");
        setIn(0, 0, 0, 0, 1, 32'h0000_1234);
        chkOut("E.c0", 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0);
        setIn(0, 0, 0, 1, 0, 0);
        chkOut("E.c1", 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1);
        setIn(0, 0, 0, 0, 1, 32'h0000_0055);     chk("E.c2.err", 32'(protocol_err), 32'h1);
        setIn(0, 0, 0, 0, 1, 32'h0000_0099);
        chkOut("E.c3", 1'b1, 32'h0, 32'h55, 1'b1, 32'h4, 1'b1);
        setIn(0, 0, 1, 0, 0, 0);
        chkOut("E.c4", 1'b1, 32'h0, 32'h55, 1'b1, 32'h4, 1'b1);
        setIn(0, 0, 0, 0, 0, 0);
        chkOut("E.c5", 1'b0, 32'h0, 32'h0, 1'b1, 32'h4, 1'b1);

        // Reset mid-stream with two buffered and two in flight.
        doRst("rstF");
        setIn(0, 0, 0, 1, 0, 0);
        setIn(0, 0, 0, 1, 0, 0);
        setIn(0, 0, 0, 1, 1, 32'h4000_0000);
        setIn(0, 0, 0, 1, 1, 32'h4000_0004);
        setIn(0, 0, 0, 1, 0, 0);
        chkOut("F.pre", 1'b1, 32'h0, 32'h4000_0000, 1'b0, 32'h10, 1'b0);
        #1 reset = 1'b1;
        #1 chkOut("F.async", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        mem_gnt = 1'b0;
        reset = 1'b0;
        setIn(0, 0, 0, 1, 0, 0);
        chkOut("F.c0", 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0);
        setIn(0, 0, 0, 0, 1, 32'h0000_0077);     chk("F.c1.valid", 32'(if_valid), 32'h0);
        setIn(0, 0, 1, 0, 0, 0);
        chkOut("F.c2", 1'b1, 32'h0, 32'h77, 1'b1, 32'h4, 1'b0);
        setIn(0, 0, 0, 0, 0, 0);
        chkOut("F.c3", 1'b0, 32'h0, 32'h0, 1'b1, 32'h4, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
